// File: rtl/alu_muldiv.sv
// RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), XLEN-generic.
// Optional MULDIV_EARLY_OUT_EN: divides with |dividend| < |divisor| finish in one cycle.
module alu_muldiv #(
    parameter int XLEN        = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            STALL,
    input  logic            FLUSH,
    input  logic [XLEN-1:0] D_PC,
    input  logic            D_VALID,
    input  logic [6:0]      D_OPCODE,
    input  logic [2:0]      D_FUNCT3,
    input  logic [6:0]      D_FUNCT7,
    input  logic [4:0]      D_REG_D,
    input  logic [4:0]      D_REG_S1,
    input  logic [4:0]      D_REG_S2,
    input  logic [XLEN-1:0] D_REG_S1_V,
    input  logic [XLEN-1:0] D_REG_S2_V,
    input  logic            FWD_M_VALID,
    input  logic [4:0]      FWD_M_REG_D,
    input  logic [XLEN-1:0] FWD_M_REG_D_V,
    input  logic            FWD_W_VALID,
    input  logic [4:0]      FWD_W_REG_D,
    input  logic [XLEN-1:0] FWD_W_REG_D_V,
    output logic [XLEN-1:0] A_PC,
    output logic            A_VALID,
    output logic [4:0]      A_REG_D,
    output logic [XLEN-1:0] A_REG_D_V,
    output logic            A_BUSY
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [4:0] idx, input logic [XLEN-1:0] v,
        input logic mv, input logic [4:0] md, input logic [XLEN-1:0] mval,
        input logic wv, input logic [4:0] wd, input logic [XLEN-1:0] wval);
        if (idx == 5'd0)             return '0;
        else if (mv && md == idx)    return mval;
        else if (wv && wd == idx)    return wval;
        else                         return v;
    endfunction

    function automatic logic [XLEN-1:0] neg_if(input logic c, input logic [XLEN-1:0] v);
        return c ? -v : v;
    endfunction

    logic [XLEN-1:0] pc_q, rs1v_q, rs2v_q;
    logic            valid_q;
    logic [6:0]      opcode_q, funct7_q;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_q, rs1_q, rs2_q;

    // Decode-side input latch
    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            pc_q <= '0; valid_q <= 1'b0; opcode_q <= '0; funct3_q <= '0; funct7_q <= '0;
            rd_q <= '0; rs1_q <= '0; rs2_q <= '0; rs1v_q <= '0; rs2v_q <= '0;
        end else if (!STALL) begin
            pc_q <= D_PC; valid_q <= D_VALID; opcode_q <= D_OPCODE; funct3_q <= D_FUNCT3;
            funct7_q <= D_FUNCT7; rd_q <= D_REG_D; rs1_q <= D_REG_S1; rs2_q <= D_REG_S2;
            rs1v_q <= D_REG_S1_V; rs2v_q <= D_REG_S2_V;
        end
    end

    logic is_m;
    logic signed [XLEN-1:0] src1, src2;
    logic            op_signed, a_neg, b_neg, is_rem, special;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    assign is_m = valid_q && opcode_q == 7'b0110011 && funct7_q == 7'b0000001;

    always_comb begin
        src1 = fwd_sel(rs1_q, rs1v_q, FWD_M_VALID, FWD_M_REG_D, FWD_M_REG_D_V,
                       FWD_W_VALID, FWD_W_REG_D, FWD_W_REG_D_V);
        src2 = fwd_sel(rs2_q, rs2v_q, FWD_M_VALID, FWD_M_REG_D, FWD_M_REG_D_V,
                       FWD_W_VALID, FWD_W_REG_D, FWD_W_REG_D_V);
        op_signed = !funct3_q[0];
        is_rem    = funct3_q[1];
        a_neg     = op_signed && src1[XLEN-1];
        b_neg     = op_signed && src2[XLEN-1];
        a_mag     = neg_if(a_neg, src1);
        b_mag     = neg_if(b_neg, src2);
        special     = 1'b0;
        special_res = '0;
        if (src2 == '0) begin
            special     = 1'b1;
            special_res = is_rem ? src1 : '1;
        end else if (op_signed && src1 == {1'b1, {(XLEN-1){1'b0}}} && src2 == '1) begin
            // Signed overflow: quotient wraps to the dividend, remainder is zero
            special     = 1'b1;
            special_res = is_rem ? '0 : src1;
        end
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [XLEN-1:0]  a_q, a_d, b_q, b_d, rem_q, rem_d, res_q, res_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d;

    logic signed [2*XLEN-1:0] mul_a, mul_b, prod;
    logic [XLEN-1:0] mul_res, rem_nx, quo_nx, div_res;
    logic [XLEN:0]   shifted;
    logic            ge;

    always_comb begin
        mul_a   = {{XLEN{(op_q[1:0] == 2'b01 || op_q[1:0] == 2'b10) && a_q[XLEN-1]}}, a_q};
        mul_b   = {{XLEN{op_q[1:0] == 2'b01 && b_q[XLEN-1]}}, b_q};
        prod    = mul_a * mul_b;
        mul_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        // Restoring step: remainder fits XLEN bits because it stays below the divisor
        shifted = {rem_q, a_q[XLEN-1]};
        ge      = shifted >= {1'b0, b_q};
        rem_nx  = ge ? (shifted[XLEN-1:0] - b_q) : shifted[XLEN-1:0];
        quo_nx  = {a_q[XLEN-2:0], ge};
        div_res = op_q[1] ? neg_if(rneg_q, rem_nx) : neg_if(qneg_q, quo_nx);
    end

    always_comb begin
        state_d = state_q; cnt_d = cnt_q; op_d = op_q; a_d = a_q; b_d = b_q;
        rem_d = rem_q; res_d = res_q; qneg_d = qneg_q; rneg_d = rneg_q;
        case (state_q)
            S_IDLE: if (is_m) begin
                op_d = funct3_q;
                if (!funct3_q[2]) begin
                    state_d = S_MUL;
                    cnt_d   = CNT_W'(MUL_LATENCY - 1);
                    a_d     = src1;
                    b_d     = src2;
                end else if (special) begin
                    state_d = S_DONE;
                    res_d   = special_res;
`ifdef MULDIV_EARLY_OUT_EN
                end else if (a_mag < b_mag) begin
                    state_d = S_DONE;
                    res_d   = is_rem ? src1 : '0;
`endif
                end else begin
                    state_d = S_DIV;
                    cnt_d   = CNT_W'(XLEN - 1);
                    a_d     = a_mag;
                    b_d     = b_mag;
                    rem_d   = '0;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    res_d   = mul_res;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DIV: begin
                a_d   = quo_nx;
                rem_d = rem_nx;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    res_d   = div_res;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: if (!STALL) state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            state_q <= S_IDLE; cnt_q <= '0; op_q <= '0; a_q <= '0; b_q <= '0;
            rem_q <= '0; res_q <= '0; qneg_q <= 1'b0; rneg_q <= 1'b0;
        end else begin
            state_q <= state_d; cnt_q <= cnt_d; op_q <= op_d; a_q <= a_d; b_q <= b_d;
            rem_q <= rem_d; res_q <= res_d; qneg_q <= qneg_d; rneg_q <= rneg_d;
        end
    end

    assign A_BUSY    = is_m && state_q != S_DONE;
    assign A_VALID   = is_m && state_q == S_DONE;
    assign A_REG_D   = rd_q;
    assign A_REG_D_V = A_VALID ? res_q : '0;
    assign A_PC      = pc_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv (XLEN=32, MUL_LATENCY=2); follows MULDIV_EARLY_OUT_EN.
module tb_alu_muldiv;
    logic        CLK = 1'b0;
    logic        RST, FLUSH, tb_stall, STALL;
    logic [31:0] D_PC, D_REG_S1_V, D_REG_S2_V;
    logic        D_VALID;
    logic [6:0]  D_OPCODE, D_FUNCT7;
    logic [2:0]  D_FUNCT3;
    logic [4:0]  D_REG_D, D_REG_S1, D_REG_S2;
    logic        FWD_M_VALID, FWD_W_VALID;
    logic [4:0]  FWD_M_REG_D, FWD_W_REG_D;
    logic [31:0] FWD_M_REG_D_V, FWD_W_REG_D_V;
    logic [31:0] A_PC, A_REG_D_V;
    logic        A_VALID, A_BUSY;
    logic [4:0]  A_REG_D;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;
    assign STALL = A_BUSY | tb_stall;

    alu_muldiv #(.XLEN(32), .MUL_LATENCY(2)) dut (
        .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH),
        .D_PC(D_PC), .D_VALID(D_VALID), .D_OPCODE(D_OPCODE), .D_FUNCT3(D_FUNCT3),
        .D_FUNCT7(D_FUNCT7), .D_REG_D(D_REG_D), .D_REG_S1(D_REG_S1), .D_REG_S2(D_REG_S2),
        .D_REG_S1_V(D_REG_S1_V), .D_REG_S2_V(D_REG_S2_V),
        .FWD_M_VALID(FWD_M_VALID), .FWD_M_REG_D(FWD_M_REG_D), .FWD_M_REG_D_V(FWD_M_REG_D_V),
        .FWD_W_VALID(FWD_W_VALID), .FWD_W_REG_D(FWD_W_REG_D), .FWD_W_REG_D_V(FWD_W_REG_D_V),
        .A_PC(A_PC), .A_VALID(A_VALID), .A_REG_D(A_REG_D), .A_REG_D_V(A_REG_D_V), .A_BUSY(A_BUSY)
    );

    task automatic issue(input logic [2:0] f3, input logic [4:0] s1, input logic [31:0] a,
                         input logic [4:0] s2, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] pc);
        @(posedge CLK); #1;
        D_VALID = 1'b1; D_OPCODE = 7'b0110011; D_FUNCT7 = 7'b0000001; D_FUNCT3 = f3;
        D_REG_S1 = s1; D_REG_S1_V = a; D_REG_S2 = s2; D_REG_S2_V = b;
        D_REG_D = rd; D_PC = pc;
        @(posedge CLK); #1;
        D_VALID = 1'b0;
    endtask

    task automatic wait_done(output logic [31:0] res, output int busy, output logic vld,
                             output logic [4:0] rdo, output logic [31:0] pco);
        @(negedge CLK);
        busy = 0;
        while (A_BUSY && busy < 200) begin
            busy++;
            @(negedge CLK);
        end
        vld = A_VALID; res = A_REG_D_V; rdo = A_REG_D; pco = A_PC;
    endtask

    task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_busy);
        logic [31:0] res, pco;
        logic [4:0]  rdo;
        logic        vld;
        int          busy;
        issue(f3, 5'd1, a, 5'd2, b, 5'd9, 32'h0000_1000 + {29'd0, f3});
        wait_done(res, busy, vld, rdo, pco);
        n_checks++;
        if (vld !== 1'b1) $display("FAIL %s valid: got %b expected 1", nm, vld);
        else n_pass++;
        n_checks++;
        if (res !== exp_res) $display("FAIL %s result: got %h expected %h", nm, res, exp_res);
        else n_pass++;
        n_checks++;
        if (busy !== exp_busy) $display("FAIL %s busy cycles: got %0d expected %0d", nm, busy, exp_busy);
        else n_pass++;
        n_checks++;
        if (rdo !== 5'd9 || pco !== 32'h0000_1000 + {29'd0, f3})
            $display("FAIL %s rd/pc: got %0d/%h expected 9/%h", nm, rdo, pco, 32'h0000_1000 + {29'd0, f3});
        else n_pass++;
    endtask

    task automatic test_reset;
        RST = 1'b1; FLUSH = 1'b0; tb_stall = 1'b0;
        D_VALID = 1'b1; D_OPCODE = 7'b0110011; D_FUNCT7 = 7'b0000001; D_FUNCT3 = 3'b000;
        D_REG_D = 5'd5; D_REG_S1 = 5'd1; D_REG_S2 = 5'd2; D_REG_S1_V = 32'd3; D_REG_S2_V = 32'd4;
        D_PC = 32'hDEAD_BEE0;
        FWD_M_VALID = 1'b0; FWD_M_REG_D = '0; FWD_M_REG_D_V = '0;
        FWD_W_VALID = 1'b0; FWD_W_REG_D = '0; FWD_W_REG_D_V = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if ({A_PC, A_VALID, A_REG_D, A_REG_D_V, A_BUSY} !== '0)
            $display("FAIL reset outputs: got pc=%h v=%b rd=%0d val=%h busy=%b expected all zero",
                     A_PC, A_VALID, A_REG_D, A_REG_D_V, A_BUSY);
        else n_pass++;
        @(posedge CLK); #1;
        RST = 1'b0; D_VALID = 1'b0;
    endtask

    task automatic test_mul;
        run_op("MUL 7*-3",     3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 3);
        run_op("MULHU 7*-3",   3'b011, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 3);
        run_op("MULH 7*-3",    3'b001, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 3);
        run_op("MULHSU -3*7u", 3'b010, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 3);
    endtask

    task automatic test_div_special;
        run_op("DIV ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("REM ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        run_op("DIVU by 0",  3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("REMU by 0",  3'b111, 32'd100, 32'd0, 32'd100, 1);
        run_op("DIV -5 by 0", 3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1);
    endtask

    task automatic test_div;
        run_op("DIV -7/2",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("REM -7/2",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("DIV 7/-2",  3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("REM 7/-2",  3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
        run_op("DIVU big/2", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33);
    endtask

    task automatic test_forward;
        logic [31:0] res, pco;
        logic [4:0]  rdo;
        logic        vld;
        int          busy;
        // x1 from M stage, changed once the divide is underway
        FWD_M_VALID = 1'b1; FWD_M_REG_D = 5'd1; FWD_M_REG_D_V = 32'd100;
        FWD_W_VALID = 1'b1; FWD_W_REG_D = 5'd1; FWD_W_REG_D_V = 32'd55;
        issue(3'b101, 5'd1, 32'd0, 5'd2, 32'd7, 5'd3, 32'h40);
        @(posedge CLK); #1;
        FWD_M_REG_D_V = 32'd50;
        wait_done(res, busy, vld, rdo, pco);
        n_checks++;
        if (vld !== 1'b1 || res !== 32'd14)
            $display("FAIL fwd M captured: got v=%b %h expected v=1 %h", vld, res, 32'd14);
        else n_pass++;
        FWD_M_VALID = 1'b0;
        FWD_W_VALID = 1'b1; FWD_W_REG_D = 5'd2; FWD_W_REG_D_V = 32'd3;
        issue(3'b000, 5'd1, 32'd7, 5'd2, 32'd0, 5'd3, 32'h44);
        wait_done(res, busy, vld, rdo, pco);
        n_checks++;
        if (res !== 32'd21) $display("FAIL fwd W: got %h expected %h", res, 32'd21);
        else n_pass++;
        FWD_M_VALID = 1'b1; FWD_M_REG_D = 5'd0; FWD_M_REG_D_V = 32'd9;
        issue(3'b000, 5'd0, 32'd5, 5'd2, 32'd7, 5'd3, 32'h48);
        wait_done(res, busy, vld, rdo, pco);
        n_checks++;
        if (res !== 32'd0) $display("FAIL x0 operand: got %h expected %h", res, 32'd0);
        else n_pass++;
        FWD_M_VALID = 1'b0; FWD_W_VALID = 1'b0;
    endtask

    task automatic test_flush;
        int seen;
        issue(3'b100, 5'd1, 32'hFFFF_FFF9, 5'd2, 32'd2, 5'd4, 32'h80);
        repeat (10) @(posedge CLK);
        #1 FLUSH = 1'b1;
        @(posedge CLK); #1 FLUSH = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (A_BUSY !== 1'b0) $display("FAIL flush busy: got %b expected 0", A_BUSY);
        else n_pass++;
        seen = 0;
        repeat (40) begin
            if (A_VALID !== 1'b0) seen++;
            @(negedge CLK);
        end
        n_checks++;
        if (seen !== 0) $display("FAIL flush no result: got %0d valid cycles expected 0", seen);
        else n_pass++;
    endtask

    task automatic test_non_m;
        @(posedge CLK); #1;
        D_VALID = 1'b1; D_OPCODE = 7'b0110011; D_FUNCT7 = 7'b0000000; D_FUNCT3 = 3'b000;
        @(posedge CLK); #1 D_VALID = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (A_BUSY !== 1'b0 || A_VALID !== 1'b0)
            $display("FAIL non-M op: got busy=%b valid=%b expected 0/0", A_BUSY, A_VALID);
        else n_pass++;
    endtask

    task automatic test_stall_done;
        logic [31:0] res, pco;
        logic [4:0]  rdo;
        logic        vld;
        int          busy;
        issue(3'b000, 5'd1, 32'd7, 5'd2, 32'hFFFF_FFFD, 5'd6, 32'hC0);
        tb_stall = 1'b1;
        wait_done(res, busy, vld, rdo, pco);
        n_checks++;
        if (vld !== 1'b1 || res !== 32'hFFFF_FFEB)
            $display("FAIL stall done entry: got v=%b %h expected v=1 %h", vld, res, 32'hFFFF_FFEB);
        else n_pass++;
        repeat (2) begin
            @(negedge CLK);
            n_checks++;
            if (A_VALID !== 1'b1 || A_REG_D_V !== 32'hFFFF_FFEB)
                $display("FAIL stall hold: got v=%b %h expected v=1 %h", A_VALID, A_REG_D_V, 32'hFFFF_FFEB);
            else n_pass++;
        end
        @(posedge CLK); #1 tb_stall = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (A_VALID !== 1'b1) $display("FAIL stall release pending: got %b expected 1", A_VALID);
        else n_pass++;
        @(negedge CLK);
        n_checks++;
        if (A_VALID !== 1'b0 || A_BUSY !== 1'b0)
            $display("FAIL back to idle: got v=%b busy=%b expected 0/0", A_VALID, A_BUSY);
        else n_pass++;
    endtask

    task automatic test_early_out;
`ifdef MULDIV_EARLY_OUT_EN
        run_op("DIVU 5/9", 3'b101, 32'd5, 32'd9, 32'd0, 1);
        run_op("REMU 5/9", 3'b111, 32'd5, 32'd9, 32'd5, 1);
        run_op("REM -5/9", 3'b110, 32'hFFFF_FFFB, 32'd9, 32'hFFFF_FFFB, 1);
`else
        run_op("DIVU 5/9", 3'b101, 32'd5, 32'd9, 32'd0, 33);
        run_op("REMU 5/9", 3'b111, 32'd5, 32'd9, 32'd5, 33);
        run_op("REM -5/9", 3'b110, 32'hFFFF_FFFB, 32'd9, 32'hFFFF_FFFB, 33);
`endif
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div_special();
        test_div();
        test_forward();
        test_flush();
        test_non_m();
        test_stall_done();
        test_early_out();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1);
    end
endmodule
